// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a small circular receive FIFO with sticky error flags.
// Define UART_RX_PARITY_EN for 8E1 framing with even-parity checking.
module uart_rx_fifo #(
  parameter int unsigned CLK_FREQ_HZ = 12500000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rxd,
  input  logic                          i_pop,
  input  logic                          i_clr_err,
  output logic [7:0]                    o_data,
  output logic                          o_valid,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_busy,
  output logic                          o_frame_err,
  output logic                          o_overrun,
  output logic                          o_parity_err
);

  localparam int unsigned DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned CW  = $clog2(DIV);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] RELOAD_FULL = CW'(DIV - 1);
  localparam logic [CW-1:0] RELOAD_HALF = CW'(DIV / 2 - 1);
  localparam logic [AW:0]   DEPTH_V     = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t        r_state;
  logic          r_sync1;
  logic          r_rx_s;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          r_frame_err;
  logic          r_overrun;

  logic          w_tick;
  logic          w_push;
  logic          w_fe_set;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_wr;
  logic          w_ovr_set;
  logic [AW:0]   w_count;

  assign w_tick   = (r_cnt == '0);
  assign w_fe_set = (r_state == S_STOP) && w_tick && !r_rx_s;
  assign w_count  = r_wptr - r_rptr;
  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (w_count == DEPTH_V);
  assign w_pop    = i_pop && !w_empty;
  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign w_wr      = w_push && (!w_full || w_pop);
  assign w_ovr_set = w_push && w_full && !w_pop;

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  logic r_parity_err;
  logic w_pe_set;

  assign w_pe_set = (r_state == S_PARITY) && w_tick && (r_rx_s ^ (^r_shift));
  assign w_push   = (r_state == S_STOP) && w_tick && r_rx_s && !r_par_bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (r_state == S_PARITY && w_tick)
        r_par_bad <= w_pe_set;
      if (w_pe_set)
        r_parity_err <= 1'b1;
      else if (i_clr_err)
        r_parity_err <= 1'b0;
    end
  end

  assign o_parity_err = r_parity_err;
`else
  assign w_push       = (r_state == S_STOP) && w_tick && r_rx_s;
  assign o_parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_sync1 <= rxd;
      r_rx_s  <= r_sync1;
      if (r_state != S_IDLE && r_state != S_BREAK && !w_tick)
        r_cnt <= r_cnt - 1'b1;
      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_cnt   <= RELOAD_HALF;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (r_rx_s) begin
              r_state <= S_IDLE;
            end else begin
              r_cnt   <= RELOAD_FULL;
              r_bit   <= '0;
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_shift <= {r_rx_s, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
            r_cnt   <= RELOAD_FULL;
            if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_tick) begin
            r_cnt   <= RELOAD_FULL;
            r_state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (w_tick)
            r_state <= r_rx_s ? S_IDLE : S_BREAK;
        end
        S_BREAK: begin
          if (r_rx_s)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++)
        r_mem[i] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr[AW-1:0]] <= r_shift;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_fe_set)
        r_frame_err <= 1'b1;
      else if (i_clr_err)
        r_frame_err <= 1'b0;
      if (w_ovr_set)
        r_overrun <= 1'b1;
      else if (i_clr_err)
        r_overrun <= 1'b0;
    end
  end

  assign o_data      = r_mem[r_rptr[AW-1:0]];
  assign o_valid     = !w_empty;
  assign o_count     = w_count;
  assign o_busy      = (r_state != S_IDLE);
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;

endmodule
